// File: rtl/rom_fetch_stage.sv
// rom_fetch_stage
//   Fetch stage in front of the 256x8 instruction ROM. Owns the program
//   counter, presents it to the ROM as a registered address, captures the
//   ROM byte one cycle later, and hands {pc, byte} to decode through a
//   2-entry FIFO with a valid/ready handshake. A credit check on
//   FIFO occupancy plus the in-flight request keeps the FIFO from ever
//   overflowing while still sustaining one byte per cycle.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   run          fetch enable; low stops new ROM requests
//   redirect     one-cycle pulse: flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address, sampled while redirect=1
//   mem_addr     ROM address (the PC register itself)
//   mem_q        ROM read data, valid the cycle after mem_addr
//   instr_valid  FIFO head holds a byte
//   instr        byte at FIFO head
//   instr_pc     address the head byte was fetched from
//   instr_ready  decode accepts the head this cycle
//   busy         request in flight or FIFO non-empty
module rom_fetch_stage #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_q,
  output logic       instr_valid,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  input  logic       instr_ready,
  output logic       busy
);

  // Stage p0: program counter, drives the ROM address.
  logic [7:0] pc_p0;

  // Stage p1: request in flight, ROM data arrives during this stage.
  logic       vld_p1;
  logic [7:0] pc_p1;

  // Stage p2: output FIFO, slot 0 is the head.
  logic [7:0] fifo_pc   [2];
  logic [7:0] fifo_data [2];
  logic [1:0] count;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;
  logic [2:0] credit_limit;
  logic [1:0] slot;

  assign pop  = (count != 2'd0) & instr_ready;
  assign push = vld_p1 & ~redirect;

  // Bytes that will occupy the FIFO once the in-flight request lands must
  // stay below two, counting a byte leaving this cycle as a freed slot.
  assign occupancy    = {1'b0, count} + {2'b00, vld_p1};
  assign credit_limit = 3'd2 + {2'b00, pop};
  assign issue        = run & ~redirect & (occupancy < credit_limit);

  // Pushed byte lands behind whatever remains after this cycle's pop.
  assign slot = count - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0        <= RESET_PC;
      vld_p1       <= 1'b0;
      pc_p1        <= 8'h00;
      count        <= 2'd0;
      fifo_pc[0]   <= 8'h00;
      fifo_pc[1]   <= 8'h00;
      fifo_data[0] <= 8'h00;
      fifo_data[1] <= 8'h00;
    end else if (redirect) begin
      // Flush: the in-flight byte and buffered bytes are discarded.
      pc_p0  <= redirect_pc;
      vld_p1 <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (issue) begin
        vld_p1 <= 1'b1;
        pc_p1  <= pc_p0;
        pc_p0  <= pc_p0 + 8'd1;
      end else begin
        vld_p1 <= 1'b0;
      end

      if (pop) begin
        fifo_pc[0]   <= fifo_pc[1];
        fifo_data[0] <= fifo_data[1];
      end

      if (push) begin
        fifo_pc[slot[0]]   <= pc_p1;
        fifo_data[slot[0]] <= mem_q;
      end

      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign mem_addr    = pc_p0;
  assign instr_valid = (count != 2'd0);
  assign instr       = fifo_data[0];
  assign instr_pc    = fifo_pc[0];
  assign busy        = vld_p1 | (count != 2'd0);

endmodule

// File: tb/tb_rom_fetch_stage.sv
// tb_rom_fetch_stage
//   Bench for rom_fetch_stage: a synchronous 256x8 ROM holding
//   byte[i] = i ^ 8'hA5, a cycle-by-cycle vector table from reset, directed
//   sequences for wrap, back-pressure, redirect and mid-stream reset, and a
//   randomized phase scored against a stream-level model (every accepted
//   byte must be the next consecutive address after reset/redirect).
module tb_rom_fetch_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] mem_addr;
  logic [7:0] mem_q = 8'h00;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic       busy;

  logic [7:0] rom [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= rom[mem_addr];

  rom_fetch_stage #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .busy        (busy)
  );

  typedef struct packed {
    logic       run;
    logic       ready;
    logic       redir;
    logic [7:0] rpc;
    logic       e_valid;
    logic [7:0] e_pc;
    logic [7:0] e_instr;
    logic [7:0] e_addr;
    logic       e_busy;
  } vec_t;

  vec_t vecs [14];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic rdir, input logic [7:0] rp);
    run         = r;
    instr_ready = rd;
    redirect    = rdir;
    redirect_pc = rp;
  endtask

  function automatic logic [7:0] romval(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Asynchronous reset pulse spanning one rising edge, released on a
  // falling edge; returns positioned at the first post-reset cycle.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk1({tag, "_rst_valid"}, instr_valid, 1'b0);
    chk8({tag, "_rst_addr"}, mem_addr, 8'h00);
    chk1({tag, "_rst_busy"}, busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_next;
    logic       prev_v, prev_run, prev_ready, prev_redir, have_prev;
    logic [7:0] prev_p, prev_d, prev_a, prev_rpc;
    logic       r_run, r_ready, r_redir;
    logic [7:0] r_rpc;
    int         streak;

    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;

    //              run ready redir rpc    valid pc     instr  addr   busy
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'hA5, 8'h02, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'hA4, 8'h03, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'hA7, 8'h04, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'hA7, 8'h04, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'hA7, 8'h04, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'hA6, 8'h05, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 8'h04, 8'hA1, 8'h06, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h40, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h41, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 8'hE5, 8'h42, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 8'hE4, 8'h42, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h42, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk1("reset_valid", instr_valid, 1'b0);
    chk8("reset_addr", mem_addr, 8'h00);
    chk8("reset_instr", instr, 8'h00);
    chk8("reset_pc", instr_pc, 8'h00);
    chk1("reset_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Vector table: outputs checked at the start of each cycle, then that
    // cycle's inputs applied.
    for (int i = 0; i < 14; i++) begin
      chk1($sformatf("vec%0d_valid", i), instr_valid, vecs[i].e_valid);
      chk8($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_valid) begin
        chk8($sformatf("vec%0d_pc", i), instr_pc, vecs[i].e_pc);
        chk8($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
      end
      drive(vecs[i].run, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
    end

    // Continuous streaming across the 0xFF -> 0x00 wrap.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    pulse_reset("wrap");
    for (int i = 0; i < 302; i++) begin
      chk1($sformatf("wrap%0d_valid", i), instr_valid, (i >= 2));
      if (i >= 2) begin
        chk8($sformatf("wrap%0d_pc", i), instr_pc, 8'(i - 2));
        chk8($sformatf("wrap%0d_instr", i), instr, romval(8'(i - 2)));
      end
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
    end

    // Mid-stream reset: everything cleared at once, restart from 0x00.
    pulse_reset("mid");
    for (int c = 0; c < 3; c++) begin
      chk1($sformatf("restart%0d_valid", c), instr_valid, (c == 2));
      if (c == 2) begin
        chk8("restart_pc", instr_pc, 8'h00);
        chk8("restart_instr", instr, 8'hA5);
      end
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
    end
    // Cycle 3: head 0x01, pc frozen at 0x03 once the FIFO fills.
    for (int s = 0; s < 10; s++) begin
      chk1($sformatf("stall%0d_valid", s), instr_valid, 1'b1);
      chk8($sformatf("stall%0d_pc", s), instr_pc, 8'h01);
      chk8($sformatf("stall%0d_addr", s), mem_addr, 8'h03);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) begin
      chk8($sformatf("resume%0d_pc", s), instr_pc, 8'(1 + s));
      chk8($sformatf("resume%0d_instr", s), instr, romval(8'(1 + s)));
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
    end
    chk8("refill_pc", instr_pc, 8'h04);
    chk8("refill_addr", mem_addr, 8'h06);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk8("full_pc", instr_pc, 8'h04);
    chk8("full_addr", mem_addr, 8'h06);
    // Redirect with a full FIFO, coincident with a pop, and run low.
    drive(1'b0, 1'b1, 1'b1, 8'h40);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk1($sformatf("rdr_hold%0d_valid", c), instr_valid, 1'b0);
      chk1($sformatf("rdr_hold%0d_busy", c), busy, 1'b0);
      chk8($sformatf("rdr_hold%0d_addr", c), mem_addr, 8'h40);
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      chk1($sformatf("rdr_go%0d_valid", c), instr_valid, (c == 2));
      if (c == 2) begin
        chk8("rdr_go_pc", instr_pc, 8'h40);
        chk8("rdr_go_instr", instr, 8'hE5);
      end
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
    end

    // Randomized phase against the stream model.
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    pulse_reset("rand");
    exp_next  = 8'h00;
    have_prev = 1'b0;
    streak    = 0;
    prev_v = 1'b0; prev_run = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
    prev_p = 8'h00; prev_d = 8'h00; prev_a = 8'h00; prev_rpc = 8'h00;
    for (int k = 0; k < 2000; k++) begin
      if (have_prev && prev_v && !prev_ready && !prev_redir) begin
        chk1("rand_hold_valid", instr_valid, 1'b1);
        chk8("rand_hold_pc", instr_pc, prev_p);
        chk8("rand_hold_instr", instr, prev_d);
      end
      if (have_prev && prev_redir) begin
        chk8("rand_redirect_addr", mem_addr, prev_rpc);
        chk1("rand_redirect_flush", instr_valid, 1'b0);
      end else if (have_prev && !prev_run) begin
        chk8("rand_run_low_addr", mem_addr, prev_a);
      end
      chk1("rand_busy_when_valid", busy | ~instr_valid, 1'b1);

      r_run   = ($urandom_range(99, 0) < 85);
      r_ready = ($urandom_range(99, 0) < 70);
      r_redir = ($urandom_range(99, 0) < 3);
      r_rpc   = 8'($urandom_range(255, 0));
      drive(r_run, r_ready, r_redir, r_rpc);

      if (instr_valid && r_ready) begin
        chk8("rand_pop_pc", instr_pc, exp_next);
        chk8("rand_pop_instr", instr, romval(exp_next));
        exp_next = exp_next + 8'd1;
      end
      if (r_redir) exp_next = r_rpc;

      if (r_run && r_ready && !r_redir && !instr_valid) begin
        streak++;
        chk1("rand_starve", (streak >= 3), 1'b0);
      end else begin
        streak = 0;
      end

      prev_v = instr_valid; prev_p = instr_pc; prev_d = instr; prev_a = mem_addr;
      prev_run = r_run; prev_ready = r_ready; prev_redir = r_redir; prev_rpc = r_rpc;
      have_prev = 1'b1;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
